// File: rtl/vga_rect_engine.sv
// vga_rect_engine: VGA raster generator drawing NUM_RECTS rectangles with fixed priority.
// Define VGA_RECT_COLLIDE_EN to add per-frame collision flags against channel 0.
module vga_rect_engine #(
  parameter int NUM_RECTS    = 4,
  parameter int CW           = 10,
  parameter int PIX_DIV      = 2,
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 751,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 491,
  parameter int V_TOTAL      = 525
) (
  input  logic                      board_clk,
  input  logic                      Reset,
  input  logic [NUM_RECTS*4*CW-1:0] rect_coords,
  input  logic [NUM_RECTS*3-1:0]    rect_color,
  input  logic [NUM_RECTS-1:0]      rect_en,
  input  logic [2:0]                bg_color,
  output logic                      vga_h_sync,
  output logic                      vga_v_sync,
  output logic                      vga_r,
  output logic                      vga_g,
  output logic                      vga_b,
  output logic [CW-1:0]             counter_x,
  output logic [CW-1:0]             counter_y,
  output logic                      frame_start,
  output logic [7:0]                frame_count,
  output logic [NUM_RECTS-1:0]      collide
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [CW-1:0] CW_ONE   = CW'(1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_LO    = CW'(H_SYNC_START);
  localparam logic [CW-1:0] HS_HI    = CW'(H_SYNC_END);
  localparam logic [CW-1:0] VS_LO    = CW'(V_SYNC_START);
  localparam logic [CW-1:0] VS_HI    = CW'(V_SYNC_END);

  logic [DW-1:0]             div_r;
  logic                      pix_en_s;
  logic [CW-1:0]             cnt_x_r, cnt_y_r;
  logic                      latch_s;
  logic [NUM_RECTS*4*CW-1:0] sh_coords_r;
  logic [NUM_RECTS*3-1:0]    sh_color_r;
  logic [NUM_RECTS-1:0]      sh_en_r;
  logic [2:0]                sh_bg_r;
  logic [NUM_RECTS-1:0]      hit_s;
  logic                      active_s, h_raw_s, v_raw_s;
  logic [NUM_RECTS-1:0]      hit1_r;
  logic                      act1_r, hs1_r, vs1_r;
  logic [2:0]                pix_s;
  logic [2:0]                rgb_r;
  logic                      hs2_r, vs2_r;
  logic                      frame_start_r;
  logic [7:0]                frame_count_r;

  assign pix_en_s = (div_r == DIV_LAST);
  assign latch_s  = pix_en_s && (cnt_x_r == {CW{1'b0}}) && (cnt_y_r == V_ACT);

  // pixel-enable divider
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      div_r <= {DW{1'b0}};
    end else if (pix_en_s) begin
      div_r <= {DW{1'b0}};
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // raster counters
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      cnt_x_r <= {CW{1'b0}};
      cnt_y_r <= {CW{1'b0}};
    end else if (pix_en_s) begin
      if (cnt_x_r == H_LAST) begin
        cnt_x_r <= {CW{1'b0}};
        cnt_y_r <= (cnt_y_r == V_LAST) ? {CW{1'b0}} : cnt_y_r + CW_ONE;
      end else begin
        cnt_x_r <= cnt_x_r + CW_ONE;
      end
    end
  end

  // shadow copy of the rectangle set, taken once per frame at the start of vertical blanking
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      sh_coords_r   <= {(NUM_RECTS*4*CW){1'b0}};
      sh_color_r    <= {(NUM_RECTS*3){1'b0}};
      sh_en_r       <= {NUM_RECTS{1'b0}};
      sh_bg_r       <= 3'b000;
      frame_count_r <= 8'd0;
    end else if (latch_s) begin
      sh_coords_r   <= rect_coords;
      sh_color_r    <= rect_color;
      sh_en_r       <= rect_en;
      sh_bg_r       <= bg_color;
      frame_count_r <= frame_count_r + 8'd1;
    end
  end

  // frame_start marks the board_clk cycle following the latch edge
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= latch_s;
    end
  end

  for (genvar g = 0; g < NUM_RECTS; g++) begin : g_hit
    logic [CW-1:0] xl_s, xr_s, yt_s, yb_s;
    assign xl_s = sh_coords_r[g*4*CW + 3*CW +: CW];
    assign xr_s = sh_coords_r[g*4*CW + 2*CW +: CW];
    assign yt_s = sh_coords_r[g*4*CW + CW +: CW];
    assign yb_s = sh_coords_r[g*4*CW +: CW];
    // inverted bounds simply fail one of the comparisons, so they never hit
    assign hit_s[g] = sh_en_r[g] && (cnt_x_r >= xl_s) && (cnt_x_r <= xr_s) &&
                      (cnt_y_r >= yt_s) && (cnt_y_r <= yb_s);
  end

  assign active_s = (cnt_x_r < H_ACT) && (cnt_y_r < V_ACT);
  assign h_raw_s  = !((cnt_x_r >= HS_LO) && (cnt_x_r <= HS_HI));
  assign v_raw_s  = !((cnt_y_r >= VS_LO) && (cnt_y_r <= VS_HI));

  // pipeline stage 1: hit vector, active flag and raw syncs
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      hit1_r <= {NUM_RECTS{1'b0}};
      act1_r <= 1'b0;
      hs1_r  <= 1'b1;
      vs1_r  <= 1'b1;
    end else if (pix_en_s) begin
      hit1_r <= hit_s;
      act1_r <= active_s;
      hs1_r  <= h_raw_s;
      vs1_r  <= v_raw_s;
    end
  end

  // priority select: scanning downwards leaves the lowest-index hit in pix_s
  always_comb begin
    pix_s = sh_bg_r;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      pix_s = hit1_r[i] ? sh_color_r[i*3 +: 3] : pix_s;
    end
    if (!act1_r) begin
      pix_s = 3'b000;
    end else begin
      pix_s = pix_s;
    end
  end

  // pipeline stage 2: final colour and syncs
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      rgb_r <= 3'b000;
      hs2_r <= 1'b1;
      vs2_r <= 1'b1;
    end else if (pix_en_s) begin
      rgb_r <= pix_s;
      hs2_r <= hs1_r;
      vs2_r <= vs1_r;
    end
  end

`ifdef VGA_RECT_COLLIDE_EN
  logic [NUM_RECTS-1:0] coll_s, acc_r, collide_r;

  // channel 0 against every other channel on active pixels
  always_comb begin
    coll_s = {NUM_RECTS{1'b0}};
    for (int i = 1; i < NUM_RECTS; i++) begin
      coll_s[i] = active_s && hit_s[0] && hit_s[i];
    end
  end

  // sticky accumulator, handed to collide and restarted at each latch
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      acc_r     <= {NUM_RECTS{1'b0}};
      collide_r <= {NUM_RECTS{1'b0}};
    end else if (latch_s) begin
      acc_r     <= coll_s;
      collide_r <= acc_r;
    end else if (pix_en_s) begin
      acc_r     <= acc_r | coll_s;
    end
  end

  assign collide = collide_r;
`else
  assign collide = {NUM_RECTS{1'b0}};
`endif

  assign vga_r       = rgb_r[2];
  assign vga_g       = rgb_r[1];
  assign vga_b       = rgb_r[0];
  assign vga_h_sync  = hs2_r;
  assign vga_v_sync  = vs2_r;
  assign counter_x   = cnt_x_r;
  assign counter_y   = cnt_y_r;
  assign frame_start = frame_start_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_rect_engine.sv
// Bench for vga_rect_engine on a shrunken raster (12x8 total, 8x6 visible) so many frames fit in a short run.
module tb_vga_rect_engine;
  localparam int NR = 4, CW = 10, PD = 2;
  localparam int HA = 8, HSS = 9, HSE = 10, HT = 12;
  localparam int VA = 6, VSS = 7, VSE = 7, VT = 8;
  localparam int FR = HT * VT;

  logic                 board_clk = 1'b0;
  logic                 Reset = 1'b1;
  logic [NR*4*CW-1:0]   rect_coords = '0;
  logic [NR*3-1:0]      rect_color = '0;
  logic [NR-1:0]        rect_en = '0;
  logic [2:0]           bg_color = 3'b001;
  logic                 vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b;
  logic [CW-1:0]        counter_x, counter_y;
  logic                 frame_start;
  logic [7:0]           frame_count;
  logic [NR-1:0]        collide;

  vga_rect_engine #(
    .NUM_RECTS(NR), .CW(CW), .PIX_DIV(PD),
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
  ) dut (
    .board_clk(board_clk), .Reset(Reset), .rect_coords(rect_coords),
    .rect_color(rect_color), .rect_en(rect_en), .bg_color(bg_color),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .counter_x(counter_x), .counter_y(counter_y),
    .frame_start(frame_start), .frame_count(frame_count), .collide(collide)
  );

  always #5 board_clk = ~board_clk;

  int vec = 0, miss = 0;
  int edges = 0, latches = 0;
  int sh_xl[NR], sh_xr[NR], sh_yt[NR], sh_yb[NR];
  bit sh_en[NR];
  logic [2:0] sh_col[NR];
  logic [2:0] sh_bg;
  int fc_m;
  bit fs_exp;
  logic [NR-1:0] acc_m, coll_m;
  int r_acc, g_acc, b_acc, last_r, last_g, last_b;
  int hs_run, vs_run, hs_len, vs_len;

  task automatic check(input string name, input int got, input int exp);
    vec++;
    if (got != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit hit_m(int i, int x, int y);
    return sh_en[i] && x >= sh_xl[i] && x <= sh_xr[i] && y >= sh_yt[i] && y <= sh_yb[i];
  endfunction

  function automatic logic [2:0] pix_m(int x, int y);
    if (x >= HA || y >= VA) return 3'b000;
    for (int i = 0; i < NR; i++) if (hit_m(i, x, y)) return sh_col[i];
    return sh_bg;
  endfunction

  function automatic logic [NR-1:0] coll_of(int x, int y);
    logic [NR-1:0] c;
    c = '0;
    if (x < HA && y < VA && hit_m(0, x, y))
      for (int i = 1; i < NR; i++) c[i] = hit_m(i, x, y);
    return c;
  endfunction

  task automatic model_reset();
    edges = 0; fc_m = 0; fs_exp = 0; acc_m = '0; coll_m = '0;
    r_acc = 0; g_acc = 0; b_acc = 0;
    for (int i = 0; i < NR; i++) begin
      sh_xl[i] = 0; sh_xr[i] = 0; sh_yt[i] = 0; sh_yb[i] = 0; sh_en[i] = 0; sh_col[i] = 3'b000;
    end
    sh_bg = 3'b000;
  endtask

  // behavioural model advanced on each rising edge; outputs compared on each falling edge
  initial begin
    int n, pre, px, py, q, qx, qy;
    logic [2:0] exp_rgb;
    model_reset();
    hs_run = 0; vs_run = 0; hs_len = 0; vs_len = 0;
    forever begin
      @(posedge board_clk);
      if (Reset) model_reset();
      else begin
        edges++;
        fs_exp = 0;
        if (edges % PD == 0) begin
          n = edges / PD;
          pre = (n - 1) % FR; px = pre % HT; py = pre / HT;
          if (px == 0 && py == VA) begin
            coll_m = acc_m;
            acc_m = coll_of(px, py);
            for (int i = 0; i < NR; i++) begin
              sh_xl[i] = int'(rect_coords[i*40+30 +: 10]);
              sh_xr[i] = int'(rect_coords[i*40+20 +: 10]);
              sh_yt[i] = int'(rect_coords[i*40+10 +: 10]);
              sh_yb[i] = int'(rect_coords[i*40 +: 10]);
              sh_en[i] = rect_en[i];
              sh_col[i] = rect_color[i*3 +: 3];
            end
            sh_bg = bg_color;
            fc_m = (fc_m + 1) % 256;
            fs_exp = 1;
            last_r = r_acc; last_g = g_acc; last_b = b_acc;
            r_acc = 0; g_acc = 0; b_acc = 0;
          end else begin
            acc_m = acc_m | coll_of(px, py);
          end
        end
      end
      @(negedge board_clk);
      if (Reset) begin
        model_reset();
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("rst_syncs", {vga_h_sync, vga_v_sync}, 3);
        check("rst_cnt", {counter_x, counter_y}, 0);
        check("rst_frame", {frame_start, frame_count, collide}, 0);
      end else begin
        n = edges / PD;
        check("counter_x", counter_x, (n % FR) % HT);
        check("counter_y", counter_y, (n % FR) / HT);
        if (n >= 2) begin
          q = (n - 2) % FR; qx = q % HT; qy = q / HT;
          exp_rgb = pix_m(qx, qy);
          check("rgb", {vga_r, vga_g, vga_b}, exp_rgb);
          check("h_sync", vga_h_sync, (qx >= HSS && qx <= HSE) ? 0 : 1);
          check("v_sync", vga_v_sync, (qy >= VSS && qy <= VSE) ? 0 : 1);
        end else begin
          check("rgb_early", {vga_r, vga_g, vga_b}, 0);
          check("syncs_early", {vga_h_sync, vga_v_sync}, 3);
        end
        check("frame_start", frame_start, fs_exp);
        check("frame_count", frame_count, fc_m);
`ifdef VGA_RECT_COLLIDE_EN
        check("collide", collide, coll_m);
`else
        check("collide", collide, 0);
`endif
        if (edges % PD == 0 && edges > 0) begin
          r_acc += vga_r; g_acc += vga_g; b_acc += vga_b;
        end
        if (!vga_h_sync) hs_run++;
        else begin if (hs_run > 0) hs_len = hs_run; hs_run = 0; end
        if (!vga_v_sync) vs_run++;
        else begin if (vs_run > 0) vs_len = vs_run; vs_run = 0; end
      end
    end
  end

  task automatic set_rect(input int i, input int xl, input int xr, input int yt, input int yb,
                          input logic [2:0] col);
    rect_coords[i*40 +: 40] = {10'(xl), 10'(xr), 10'(yt), 10'(yb)};
    rect_color[i*3 +: 3] = col;
  endtask

  task automatic wait_latch();
    int t;
    t = 0;
    do begin @(negedge board_clk); t++; end while (!frame_start && t < 400);
    if (!frame_start) begin
      vec++; miss++;
      $display("FAIL latch_timeout: got no frame_start within %0d cycles expected a pulse", t);
    end
    latches++;
    @(posedge board_clk); #2;
  endtask

  initial begin
    repeat (3) @(posedge board_clk);
    #2 Reset = 1'b0;
    repeat (4) @(posedge board_clk);
    @(negedge board_clk);
    check("cx_after_release", counter_x, 2);
    @(posedge board_clk); #2;

    set_rect(0, 1, 3, 1, 2, 3'b100);
    rect_en = 4'b0001;
    wait_latch();
    check("fc_first", frame_count, 1);
    wait_latch();
    check("red_px_f1", last_r, 6);
    check("blue_px_f1", last_b, 42);

    set_rect(1, 2, 5, 2, 4, 3'b010);
    set_rect(2, 5, 2, 0, 5, 3'b111);
    set_rect(3, 7, 7, 5, 5, 3'b011);
    rect_en = 4'b1111;
    wait_latch();
    wait_latch();
    check("red_px_ovl", last_r, 6);
    check("green_px_ovl", last_g, 11);
    check("blue_px_ovl", last_b, 32);
    check("hsync_low_cycles", hs_len, 4);
    check("vsync_low_cycles", vs_len, 24);

    repeat (120) @(posedge board_clk);
    #2 set_rect(0, 4, 7, 3, 5, 3'b100);
    wait_latch();
    check("red_px_no_tear", last_r, 6);
    wait_latch();
    check("red_px_moved", last_r, 12);

    while (latches < 256) wait_latch();
    check("fc_wrap", frame_count, 0);

    repeat (50) @(posedge board_clk);
    #2 Reset = 1'b1;
    @(negedge board_clk);
    check("midrst_hsync", vga_h_sync, 1);
    check("midrst_cx", counter_x, 0);
    repeat (3) @(posedge board_clk);
    #2 Reset = 1'b0;
    repeat (4) @(posedge board_clk);
    @(negedge board_clk);
    check("cx_after_midrst", counter_x, 2);
    @(posedge board_clk); #2;
    wait_latch();
    check("blue_px_blank_shadow", last_b, 0);
    wait_latch();
    check("blue_px_after_rst", last_b, 28);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
